// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding,
// frame layout and the parity helper.
package uart_pkg;

  localparam int unsigned FRAME_W  = 10;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned PAR_BIT  = 8;
  localparam int unsigned STOP_BIT = 9;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_LISTEN   = 2'd1,
    ST_CHECK    = 2'd2,
    ST_STORE    = 2'd3
  } rx_state_t;

  // True when data XOR parity matches the expected sense (0 = even, 1 = odd).
  function automatic logic parity_ok(input logic [DATA_MSB:0] data,
                                     input logic parity,
                                     input logic odd);
    return ((^data) ^ parity) == odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small show-ahead FIFO for received bytes. Pointers wrap modulo DEPTH and
// occupancy is tracked separately so full and empty stay distinct.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates the receiver, captures frames, checks
// parity/stop, buffers good bytes and keeps sticky error status.
// Optional macro UART_RX_TIMEOUT_EN adds the rx_timeout output.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned PTR_W          = 2,
  parameter int unsigned PARITY_ODD     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [FRAME_W-1:0] rx_frame,
  input  logic               rx_char_received,
  output logic               rx_enable,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  input  logic               rd_ack,
  output logic [PTR_W:0]     count,
  output logic               err_parity,
  output logic               err_frame,
  output logic               err_overrun,
`ifdef UART_RX_TIMEOUT_EN
  output logic               rx_timeout,
`endif
  input  logic               clr_err
);

  rx_state_t          state, state_nxt;
  logic [FRAME_W-1:0] frame_q;
  logic               par_ok_q;
  logic               stop_ok_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               good;
  logic               set_par, set_frm, set_ovr;

  assign pop      = rd_ack & ~fifo_empty;
  assign rd_valid = ~fifo_empty;
  assign good     = par_ok_q & stop_ok_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_DISABLED;
    else       state <= state_nxt;
  end

  // Next-state, receiver enable, push and error-set decisions.
  always_comb begin
    state_nxt = state;
    rx_enable = 1'b0;
    push      = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    set_ovr   = 1'b0;
    unique case (state)
      ST_DISABLED: begin
        if (en) state_nxt = ST_LISTEN;
      end
      ST_LISTEN: begin
        rx_enable = 1'b1;
        if (rx_char_received) state_nxt = ST_CHECK;
        else if (!en)         state_nxt = ST_DISABLED;
      end
      ST_CHECK: begin
        rx_enable = 1'b1;
        set_ovr   = rx_char_received;
        state_nxt = ST_STORE;
      end
      ST_STORE: begin
        rx_enable = 1'b1;
        set_par   = ~par_ok_q;
        set_frm   = ~stop_ok_q;
        // Full FIFO only loses the byte when no pop frees a slot this cycle.
        push      = good & (~fifo_full | pop);
        set_ovr   = rx_char_received | (good & fifo_full & ~pop);
        state_nxt = en ? ST_LISTEN : ST_DISABLED;
      end
      default: state_nxt = ST_DISABLED;
    endcase
  end

  // Frame capture in LISTEN and check results in CHECK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q   <= '0;
      par_ok_q  <= 1'b0;
      stop_ok_q <= 1'b0;
    end else begin
      if (state == ST_LISTEN && rx_char_received) frame_q <= rx_frame;
      if (state == ST_CHECK) begin
        par_ok_q  <= parity_ok(frame_q[DATA_MSB:0], frame_q[PAR_BIT],
                               PARITY_ODD != 0);
        stop_ok_q <= frame_q[STOP_BIT];
      end
    end
  end

  // Sticky error flags; a set wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_parity  <= set_par | (err_parity  & ~clr_err);
      err_frame   <= set_frm | (err_frame   & ~clr_err);
      err_overrun <= set_ovr | (err_overrun & ~clr_err);
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (rd_ack),
    .wdata (frame_q[DATA_MSB:0]),
    .rdata (rd_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Idle counter: restarts on any FIFO activity or while empty, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         to_cnt <= '0;
    else if (push || pop || fifo_empty) to_cnt <= '0;
    else if (to_cnt != '1)             to_cnt <= to_cnt + 1'b1;
  end

  assign rx_timeout = ~fifo_empty & (to_cnt >= TO_W'(TIMEOUT_CYCLES));
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [9:0] rx_frame;
  logic       rx_char_received;
  logic       rx_enable;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ack;
  logic [2:0] count;
  logic       err_parity, err_frame, err_overrun;
  logic       clr_err;

  int unsigned tests  = 0;
  int unsigned failed = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH          (4),
    .PTR_W          (2),
    .PARITY_ODD     (0),
    .TIMEOUT_CYCLES (2048)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .en               (en),
    .rx_frame         (rx_frame),
    .rx_char_received (rx_char_received),
    .rx_enable        (rx_enable),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .rd_ack           (rd_ack),
    .count            (count),
    .err_parity       (err_parity),
    .err_frame        (err_frame),
    .err_overrun      (err_overrun),
`ifdef UART_RX_TIMEOUT_EN
    .rx_timeout       (),
`endif
    .clr_err          (clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b0 && rd_valid === 1'b1 && rd_ack === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL read_unexpected: got %0h expected none", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          failed++;
          $display("FAIL read_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse one frame; returns 1 ns after the capturing edge (FSM in CHECK).
  task automatic send_frame(input logic [9:0] f);
    step(1);
    rx_frame = f;
    rx_char_received = 1'b1;
    step(1);
    rx_char_received = 1'b0;
  endtask

  // Full frame handling: returns with FSM back in LISTEN/DISABLED.
  task automatic send_wait(input logic [9:0] f);
    send_frame(f);
    step(2);
  endtask

  task automatic read_one();
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; rx_frame = '0; rx_char_received = 1'b0;
    rd_ack = 1'b0; clr_err = 1'b0;
    #23;
    check("reset_count", 32'(count), 0);
    check("reset_valid", 32'(rd_valid), 0);
    check("reset_data", 32'(rd_data), 0);
    check("reset_rx_enable", 32'(rx_enable), 0);
    check("reset_errs", {29'd0, err_parity, err_frame, err_overrun}, 0);
    reset = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
    check("listen_rx_enable", 32'(rx_enable), 1);

    // Good frame with latency check.
    exp_q.push_back(8'hA5);
    send_frame(10'h2A5);
    step(1);
    check("latency_not_yet", 32'(rd_valid), 0);
    step(1);
    check("latency_valid", 32'(rd_valid), 1);
    check("good_data", 32'(rd_data), 32'h A5);
    check("good_count", 32'(count), 1);
    check("good_errs", {29'd0, err_parity, err_frame, err_overrun}, 0);
    read_one();
    check("good_drained", 32'(count), 0);

    // Parity error, then clear.
    send_wait(10'h3A5);
    check("par_err", 32'(err_parity), 1);
    check("par_count", 32'(count), 0);
    check("par_no_frame_err", 32'(err_frame), 0);
    pulse_clr();
    check("par_cleared", 32'(err_parity), 0);

    // Stop-bit error.
    send_wait(10'h0A5);
    check("frm_err", 32'(err_frame), 1);
    check("frm_no_par_err", 32'(err_parity), 0);
    check("frm_count", 32'(count), 0);
    pulse_clr();

    // Fill and overrun.
    exp_q.push_back(8'h01); send_wait(10'h301);
    exp_q.push_back(8'h02); send_wait(10'h302);
    exp_q.push_back(8'h03); send_wait(10'h203);
    exp_q.push_back(8'h04); send_wait(10'h304);
    check("full_count", 32'(count), 4);
    check("full_no_ovr", 32'(err_overrun), 0);
    send_wait(10'h205);
    check("ovr_set", 32'(err_overrun), 1);
    check("ovr_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) read_one();
    check("drain_count", 32'(count), 0);
    check("drain_valid", 32'(rd_valid), 0);
    pulse_clr();
    check("ovr_cleared", 32'(err_overrun), 0);

    // Simultaneous push and pop on a full FIFO.
    exp_q.push_back(8'h01); send_wait(10'h301);
    exp_q.push_back(8'h02); send_wait(10'h302);
    exp_q.push_back(8'h03); send_wait(10'h203);
    exp_q.push_back(8'h04); send_wait(10'h304);
    exp_q.push_back(8'h55);
    send_frame(10'h255);
    step(1);
    read_one();
    check("pp_no_ovr", 32'(err_overrun), 0);
    check("pp_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) read_one();
    check("pp_drain", 32'(count), 0);

    // Pulse while in CHECK: second frame dropped as overrun.
    exp_q.push_back(8'hA5);
    send_frame(10'h2A5);
    rx_frame = 10'h255;
    rx_char_received = 1'b1;
    step(1);
    rx_char_received = 1'b0;
    step(1);
    check("busy_ovr", 32'(err_overrun), 1);
    check("busy_count", 32'(count), 1);
    read_one();
    pulse_clr();

    // en dropped during CHECK: frame completes, then receiver disabled.
    exp_q.push_back(8'hA5);
    send_frame(10'h2A5);
    en = 1'b0;
    step(2);
    check("dis_count", 32'(count), 1);
    check("dis_rx_enable", 32'(rx_enable), 0);
    en = 1'b1;
    step(1);
    exp_q.push_back(8'h55);
    send_wait(10'h255);
    check("pre_reset_count", 32'(count), 2);

    // Asynchronous reset mid-cycle clears the FIFO at once.
    #3;
    reset = 1'b1;
    #1;
    check("async_count", 32'(count), 0);
    check("async_valid", 32'(rd_valid), 0);
    exp_q.delete();
    step(1);
    reset = 1'b0;
    step(1);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
